// File: rtl/bcd_pkg.sv
// Shared BCD operand-format types for the encoder and the BCD ALU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

  // One packed BCD digit, 0..9 in valid data.
  typedef logic [3:0] bcd_digit_t;

  // ALU operand/result word: sign-magnitude, two BCD digits.
  typedef struct packed {
    logic       sign;
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_word_t;

  // Largest magnitude representable in a bcd_word_t.
  localparam int BCD_MAX = 99;

  // Scratch digits used by the encoder: ones, tens, hundreds, thousands.
  // Four digits cover the largest legal input magnitude (2^13 = 8192).
  localparam int ENC_DIGITS    = 4;
  localparam int ENC_SCRATCH_W = 4 * ENC_DIGITS;

  // Encoder control states.
  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_SHIFT = 2'd1,
    ENC_DONE  = 2'd2
  } enc_state_t;

  // Builds an output word; a zero magnitude always carries a positive sign.
  function automatic bcd_word_t bcd_make_word(input logic       sign,
                                              input bcd_digit_t tens,
                                              input bcd_digit_t ones);
    bcd_word_t w;
    w.tens = tens;
    w.ones = ones;
    w.sign = sign & ((tens != 4'd0) | (ones != 4'd0));
    return w;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  // A digit >= 5 would become >= 10 after the next shift; pre-bias it by 3
  // so the shift carries into the next digit instead.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_encoder.sv
// Signed binary to sign-magnitude BCD {sign, tens, ones} by double-dabble, one bit per cycle.
// Latency: DATA_W cycles from input accept to out_valid; one idle cycle after each output handshake.
// Backpressure: holds the result in DONE indefinitely while out_ready=0; in_ready only in IDLE.
// Optional build macro BCD_ENC_SAT_EN: saturate overflowing results to +/-99 instead of wrapping mod 100.
module bcd_encoder
  import bcd_pkg::*;
#(
  // Legal range 4..14: four scratch digits and a 4-bit counter cover this.
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_bcd,
  output logic              out_ovf
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  enc_state_t               state_q, state_d;
  logic [3:0]               count_q, count_d;
  logic [DATA_W-1:0]        mag_q, mag_d;
  logic [ENC_SCRATCH_W-1:0] scratch_q, scratch_d;
  logic                     sign_q, sign_d;
  logic                     out_valid_q, out_valid_d;
  bcd_word_t                word_q, word_d;
  logic                     ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]        abs_in;
  logic [ENC_SCRATCH_W-1:0] corr;
  logic [ENC_SCRATCH_W-1:0] shifted;
  logic                     ovf_next;
  bcd_digit_t               tens_next;
  bcd_digit_t               ones_next;
  bcd_word_t                word_next;

  // The thousands digit never exceeds 8 for legal widths, so its
  // corrected MSB would only ever shift out of the scratch.
  logic                     unused_corr_msb;
  assign unused_corr_msb = corr[ENC_SCRATCH_W-1];

  // Magnitude in DATA_W bits: the most negative value maps to 2^(DATA_W-1),
  // which is still representable as an unsigned DATA_W-bit number.
  always_comb begin
    abs_in = in_data;
    if (in_data[DATA_W-1]) begin
      abs_in = {DATA_W{1'b0}} - in_data;
    end
  end

  // One add-3 corrector per scratch digit.
  for (genvar g = 0; g < ENC_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (corr[4*g +: 4])
    );
  end

  // Corrected scratch shifted left with the next magnitude bit entering.
  assign shifted = {corr[ENC_SCRATCH_W-2:0], mag_q[DATA_W-1]};

  // Result as it will look after the current shift; only captured on the
  // final shift so the output registers change only at DONE entry.
  always_comb begin
    ovf_next  = (shifted[15:8] != 8'd0);
    tens_next = shifted[7:4];
    ones_next = shifted[3:0];
`ifdef BCD_ENC_SAT_EN
    if (ovf_next) begin
      tens_next = 4'd9;
      ones_next = 4'd9;
    end
`endif
    word_next = bcd_make_word(sign_q, tens_next, ones_next);
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == ENC_IDLE);

  // Next-state and datapath update for the accept / shift / hold sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mag_d       = mag_q;
    scratch_d   = scratch_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    word_d      = word_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      ENC_IDLE: begin
        if (in_valid) begin
          state_d   = ENC_SHIFT;
          sign_d    = in_data[DATA_W-1];
          mag_d     = abs_in;
          scratch_d = '0;
          count_d   = 4'(DATA_W);
        end
      end

      ENC_SHIFT: begin
        scratch_d = shifted;
        mag_d     = {mag_q[DATA_W-2:0], 1'b0};
        count_d   = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d     = ENC_DONE;
          out_valid_d = 1'b1;
          word_d      = word_next;
          ovf_d       = ovf_next;
        end
      end

      ENC_DONE: begin
        if (out_ready) begin
          state_d     = ENC_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ENC_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ENC_IDLE;
      count_q     <= 4'd0;
      mag_q       <= '0;
      scratch_q   <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mag_q       <= mag_d;
      scratch_q   <= scratch_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = word_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_encoder.sv
// Directed bench for bcd_encoder (DATA_W=8) with an arithmetic reference model.
// Honours BCD_ENC_SAT_EN the same way the design does.
module tb_bcd_encoder;

  localparam int DATA_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_bcd;
  logic       out_ovf;

  bcd_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the conversion in flight.
  logic [8:0] exp_bcd = 9'h000;
  logic       exp_ovf = 1'b0;
  int         acc_cyc = 0;
  bit         pending = 1'b0;
  bit         seen    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitude, overflow above 99, wrap or saturate, no negative zero.
  function automatic logic [9:0] model(input int x);
    int   m;
    int   v;
    logic ovf;
    logic sgn;
    m   = (x < 0) ? -x : x;
    ovf = (m > 99);
    v   = m % 100;
`ifdef BCD_ENC_SAT_EN
    if (ovf) v = 99;
`endif
    sgn = (x < 0) && (v != 0);
    return {ovf, sgn, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    bit ok;
    ok = 1'b0;
    in_data  = 8'(x);
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    {exp_ovf, exp_bcd} = model(x);
    step();
    acc_cyc  = cyc;
    pending  = 1'b1;
    seen     = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int stall, input bit has_lit,
                      input logic [8:0] lit_bcd, input logic lit_ovf);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      pending = 1'b0;
      return;
    end
    if (has_lit) begin
      chk("lit_bcd", 32'(out_bcd), 32'(lit_bcd));
      chk("lit_ovf", 32'(out_ovf), 32'(lit_ovf));
    end
    // Stall with a competing input offered; it must be ignored.
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = 8'd12;
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pending   = 1'b0;
    seen      = 1'b0;
    chk("ready_after_hs", 32'(in_ready), 32'd1);
    chk("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  // Continuous check of every cycle the outputs are presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("unexpected_valid", 32'(out_valid), 32'(pending));
      if (pending) begin
        if (!seen) begin
          chk("latency", 32'(cyc - acc_cyc), 32'(DATA_W));
          seen = 1'b1;
        end
        chk("bcd", 32'(out_bcd), 32'(exp_bcd));
        chk("ovf", 32'(out_ovf), 32'(exp_ovf));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd",   32'(out_bcd),   32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    step();

    // Basic conversions with hand-computed results
    send(47);   recv(0, 1'b1, 9'h047, 1'b0);
    send(-35);  recv(0, 1'b1, 9'h135, 1'b0);
    send(0);    recv(0, 1'b1, 9'h000, 1'b0);
`ifdef BCD_ENC_SAT_EN
    send(127);  recv(0, 1'b1, 9'h099, 1'b1);
    send(-128); recv(0, 1'b1, 9'h199, 1'b1);
    send(-100); recv(0, 1'b1, 9'h199, 1'b1);
`else
    send(127);  recv(0, 1'b1, 9'h027, 1'b1);
    send(-128); recv(0, 1'b1, 9'h128, 1'b1);
    send(-100); recv(0, 1'b1, 9'h000, 1'b1);
`endif
    send(-99);  recv(0, 1'b1, 9'h199, 1'b0);

    // Backpressure for 5 cycles with new input offered
    send(63);   recv(5, 1'b1, 9'h063, 1'b0);

    // Reset during the third shift cycle
    send(50);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    pending = 1'b0;
    seen    = 1'b0;
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("no_result_after_rst", 32'(out_valid), 32'd0);
    send(99);   recv(0, 1'b1, 9'h099, 1'b0);

    // Full input range against the model
    for (int x = -128; x <= 127; x++) begin
      send(x);
      recv(0, 1'b0, 9'h000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound in case the DUT wedges somewhere unexpected.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
